// File: rtl/poly_ready_generator.sv
// poly_ready_generator: polyphonic tick generator.
// Up to NUM_VOICES of the pressed keys are each given a voice. Every voice
// counts up to a key-dependent divider and emits a one-cycle ready pulse
// each time it reaches it.
// Optional feature: define POLY_READY_TONE_EN to get a per-voice square wave
// on tone; without it tone is tied to 0.
module poly_ready_generator #(
  parameter int unsigned NUM_KEYS   = 17,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned SHIFT_W    = 2
) (
  input  logic                  clk,
  input  logic                  restart,
  input  logic [NUM_KEYS-1:0]   key_num,
  input  logic [SHIFT_W-1:0]    shift,
  output logic [NUM_VOICES-1:0] ready,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [NUM_VOICES-1:0] tone
);

  localparam int unsigned KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [KEY_W-1:0]      key_d [NUM_VOICES];
  logic [KEY_W-1:0]      key_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] act_d, act_q;
  logic [CNT_W-1:0]      div_d [NUM_VOICES];
  logic [CNT_W-1:0]      div_q [NUM_VOICES];
  logic [CNT_W-1:0]      cnt_d [NUM_VOICES];
  logic [CNT_W-1:0]      cnt_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] rdy_d, rdy_q;
  logic [NUM_VOICES-1:0] chg;

  // Divider for a key: semitone base value shifted down by octave plus shift.
  function automatic logic [CNT_W-1:0] div_of(input logic [KEY_W-1:0] key,
                                              input logic [SHIFT_W-1:0] sh);
    logic [10:0] b;
    int unsigned k;
    int unsigned amt;
    k   = 32'(key);
    amt = k / 12 + 32'(sh);
    case (k % 12)
      0:       b = 11'd1612;
      1:       b = 11'd1522;
      2:       b = 11'd1437;
      3:       b = 11'd1356;
      4:       b = 11'd1280;
      5:       b = 11'd1208;
      6:       b = 11'd1140;
      7:       b = 11'd1076;
      8:       b = 11'd1016;
      9:       b = 11'd959;
      10:      b = 11'd905;
      default: b = 11'd854;
    endcase
    div_of = CNT_W'(b >> amt);
  endfunction

  // Allocation: voice v takes the (v+1)-th pressed key in ascending index.
  always_comb begin
    int unsigned n;
    n = 0;
    act_d = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) key_d[v] = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (key_num[NUM_KEYS-1-i]) begin
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (n == v) begin
            key_d[v] = KEY_W'(i);
            act_d[v] = 1'b1;
          end
        end
        n = n + 1;
      end
    end
  end

  // Per-voice divider from the registered allocation and the live shift.
  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) div_d[v] = div_of(key_q[v], shift);
  end

  // Per-voice counter: restart on allocation change, else count to divider.
  always_comb begin
    rdy_d = '0;
    chg   = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      cnt_d[v] = '0;
      chg[v]   = (key_d[v] != key_q[v]) || (act_d[v] != act_q[v]);
      if (!chg[v] && act_q[v]) begin
        if (cnt_q[v] >= div_q[v]) begin
          rdy_d[v] = 1'b1;
        end else begin
          cnt_d[v] = cnt_q[v] + 1'b1;
        end
      end
    end
  end

  // Allocation, divider, counter and pulse registers.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        key_q[v] <= '0;
        div_q[v] <= '0;
        cnt_q[v] <= '0;
      end
      act_q <= '0;
      rdy_q <= '0;
    end else begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        key_q[v] <= key_d[v];
        div_q[v] <= div_d[v];
        cnt_q[v] <= cnt_d[v];
      end
      act_q <= act_d;
      rdy_q <= rdy_d;
    end
  end

  assign ready        = rdy_q;
  assign voice_active = act_q;

`ifdef POLY_READY_TONE_EN
  logic [NUM_VOICES-1:0] tone_d, tone_q;

  // Square wave: toggle on each tick, zero when the voice is idle or re-keyed.
  always_comb begin
    tone_d = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!chg[v] && act_q[v]) tone_d[v] = tone_q[v] ^ rdy_d[v];
    end
  end

  // Tone register.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) tone_q <= '0;
    else         tone_q <= tone_d;
  end

  assign tone = tone_q;
`else
  assign tone = '0;
`endif

endmodule

// File: tb/tb_poly_ready_generator.sv
// Scoreboard bench for poly_ready_generator: the driver runs a timestamp-based
// reference model at each edge and queues the expected outputs; a monitor pops
// and compares on every falling edge and also measures tick periods.
module tb_poly_ready_generator;

  localparam int NK = 17;
  localparam int NV = 4;
  localparam int CW = 12;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          restart = 1'b1;
  logic [NK-1:0] key_num = '0;
  logic [SW-1:0] shift = '0;
  logic [NV-1:0] ready, voice_active, tone;

  poly_ready_generator #(
    .NUM_KEYS(NK), .NUM_VOICES(NV), .CNT_W(CW), .SHIFT_W(SW)
  ) dut (
    .clk(clk), .restart(restart), .key_num(key_num), .shift(shift),
    .ready(ready), .voice_active(voice_active), .tone(tone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NV-1:0] rdy;
    logic [NV-1:0] act;
    logic [NV-1:0] tn;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  int base_tab[12] = '{1612, 1522, 1437, 1356, 1280, 1208, 1140, 1076, 1016, 959, 905, 854};
  int  m_key[NV];
  bit  m_act[NV];
  int  m_div[NV];   // divider in force at the coming edge
  int  m_last[NV];  // edge number of the last counter clear
  bit  m_tone[NV];
  int  m_edge = 0;
`ifdef POLY_READY_TONE_EN
  localparam bit TONE_EN = 1'b1;
`else
  localparam bit TONE_EN = 1'b0;
`endif

  function automatic int divider(int key, int s);
    return (base_tab[key % 12] >> (key / 12 + s)) & ((1 << CW) - 1);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_key[v] = 0; m_act[v] = 0; m_div[v] = 0; m_last[v] = 0; m_tone[v] = 0;
    end
  endtask

  task automatic model_edge(input logic [NK-1:0] k, input int s);
    int   idx[$];
    exp_t e;
    bit   new_act, changed;
    int   new_key;
    e = '0;
    m_edge++;
    for (int i = 0; i < NK; i++) if (k[NK-1-i]) idx.push_back(i);
    for (int v = 0; v < NV; v++) begin
      new_act = (v < idx.size());
      new_key = new_act ? idx[v] : 0;
      changed = (new_act != m_act[v]) || (new_act && new_key != m_key[v]);
      if (changed) begin
        m_last[v] = m_edge;
        m_tone[v] = 0;
      end else if (m_act[v]) begin
        if (m_edge - 1 - m_last[v] >= m_div[v]) begin
          e.rdy[v]  = 1'b1;
          m_last[v] = m_edge;
          m_tone[v] = TONE_EN ? ~m_tone[v] : 1'b0;
        end
      end else begin
        m_tone[v] = 0;
      end
      m_div[v] = divider(m_key[v], s);
      m_key[v] = new_key;
      m_act[v] = new_act;
      e.act[v] = new_act;
      e.tn[v]  = m_tone[v];
    end
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  int last_pulse[NV];
  int period[NV];

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int v = 0; v < NV; v++) begin
      if (ready[v]) begin
        if (last_pulse[v] >= 0) period[v] = cyc - last_pulse[v];
        last_pulse[v] = cyc;
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (ready !== e.rdy || voice_active !== e.act || tone !== e.tn) begin
        miscompares++;
        $display("FAIL outputs cycle %0d: ready=%b active=%b tone=%b, required ready=%b active=%b tone=%b",
                 cyc, ready, voice_active, tone, e.rdy, e.act, e.tn);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic clear_periods();
    for (int v = 0; v < NV; v++) begin last_pulse[v] = -1; period[v] = 0; end
  endtask

  task automatic run(input logic [NK-1:0] k, input int s, input int n);
    for (int i = 0; i < n; i++) begin
      key_num = k;
      shift   = SW'(s);
      @(posedge clk);
      model_edge(k, s);
      #1;
    end
  endtask

  // Assert restart just after a monitor sample, hold it, release it.
  task automatic pulse_restart(input int hold);
    exp_t z;
    z = '0;
    @(negedge clk);
    #1 restart = 1'b1;
    #1;
    check("outputs_zero_on_restart", int'({ready, voice_active, tone}), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      exp_q.push_back(z);
      #1;
    end
    restart = 1'b0;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [NK-1:0] k;
    clear_periods();
    model_reset();
    #1;
    check("reset_state", int'({ready, voice_active, tone}), 0);
    @(posedge clk);
    #1 restart = 1'b0;

    // Single lowest key: period 1613, other voices idle.
    clear_periods();
    run(17'h10000, 0, 3300);
    check("key0_period", period[0], 1613);
    check("key0_idle_voices", last_pulse[1] + last_pulse[2] + last_pulse[3], -3);

    // A and E with shift 1: independent periods 480 and 321.
    run('0, 0, 2);
    clear_periods();
    run(17'h00081, 1, 1100);
    check("A_period", period[0], 480);
    check("E_period", period[1], 321);

    // Five keys, four voices; then release index 2.
    run('0, 0, 2);
    clear_periods();
    run(17'h15280, 3, 500);
    check("five_v0_period", period[0], 202);
    check("five_v3_period", period[3], 135);
    clear_periods();
    run(17'h11280, 3, 600);
    check("rel_v0_period", period[0], 202);
    check("rel_v1_period", period[1], 161);
    check("rel_v3_period", period[3], 120);

    // Restart mid-count at counter 500, then fresh start.
    run('0, 0, 2);
    run(17'h10000, 0, 501);
    pulse_restart(3);
    clear_periods();
    run(17'h10000, 0, 1700);
    check("post_restart_first_tick", last_pulse[0] > 0, 1);

    // Shift change 0->3 at counter 300, then period 202.
    run('0, 0, 2);
    run(17'h10000, 0, 301);
    clear_periods();
    run(17'h10000, 3, 700);
    check("shift_period", period[0], 202);

    // Randomized segments.
    for (int seg = 0; seg < 16; seg++) begin
      k = NK'($urandom & $urandom & $urandom);
      if (seg % 5 == 4) k = '0;
      run(k, int'($urandom_range(0, 3)), int'($urandom_range(20, 300)));
      if (seg == 9) pulse_restart(int'($urandom_range(1, 4)));
    end
    run('0, 0, 5);

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
